// File: rtl/arith_drv_pkg.sv
// arith_drv_pkg: shared types for the arithmetic job driver.
// One-hot state encoding, output bundle and parameter defaults.
package arith_drv_pkg;

  localparam int DEF_ADD_CYC = 1;
  localparam int DEF_MUL_GAP = 1;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_START = 7'b0000010,
    S_ADD   = 7'b0000100,
    S_GAP   = 7'b0001000,
    S_MUL   = 7'b0010000,
    S_WAIT  = 7'b0100000,
    S_RESP  = 7'b1000000
  } state_e;

  typedef struct packed {
    logic        req_ready;
    logic        start;
    logic        add_en;
    logic        mul_en;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] fifo_in;
    logic        rsp_valid;
    logic [15:0] rsp_result;
    logic [15:0] rsp_fifo;
    logic [15:0] rsp_tag;
    logic        rsp_err;
  } drv_out_t;

endpackage

// File: rtl/arith_job_driver_if.sv
// arith_job_driver_if: request, target and response signals.
// master is the driver side, slave is the environment side.
interface arith_job_driver_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic [15:0] req_tag;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        add_en;
  logic        mul_en;
  logic [15:0] fifo_in;
  logic [15:0] result;
  logic        done;
  logic [15:0] fifo_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [15:0] rsp_fifo;
  logic [15:0] rsp_tag;
  logic        rsp_err;

  modport master (
    input  req_valid, req_a, req_b, req_tag,
    input  result, done, fifo_out, rsp_ready,
    output req_ready, start, a, b, add_en, mul_en,
    output fifo_in, rsp_valid, rsp_result,
    output rsp_fifo, rsp_tag, rsp_err
  );

  modport slave (
    output req_valid, req_a, req_b, req_tag,
    output result, done, fifo_out, rsp_ready,
    input  req_ready, start, a, b, add_en, mul_en,
    input  fifo_in, rsp_valid, rsp_result,
    input  rsp_fifo, rsp_tag, rsp_err
  );
endinterface

// File: rtl/arith_drv_timer.sv
// arith_drv_timer: clearable 8-bit up-counter.
// tc_o flags the cycle in which the LIMIT-th count is reached.
module arith_drv_timer #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt_q, cnt_d;

  // next count: clear wins, saturate at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/arith_job_driver.sv
// arith_job_driver: sequences one job through an add/mul target.
// All outputs are registered from the next state (Moore).
module arith_job_driver
  import arith_drv_pkg::*;
#(
  parameter int ADD_CYC = DEF_ADD_CYC,
  parameter int MUL_GAP = DEF_MUL_GAP,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               rst_n,
  arith_job_driver_if.master bus
);

  localparam logic [7:0] ADD_LAST = 8'(ADD_CYC - 1);
  localparam logic [7:0] GAP_LAST = 8'(MUL_GAP - 1);

  logic [1:0]  sync_q;
  logic        rst_s_n;
  state_e      state_q, state_d;
  logic [7:0]  ph_q, ph_d;
  logic [7:0]  op_a_q, op_a_d;
  logic [7:0]  op_b_q, op_b_d;
  logic [15:0] tag_q, tag_d;
  drv_out_t    out_q, out_d;
  logic        busy;
  logic        tmo;

  // reset: assert at once, release after two clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], 1'b1};
  end

  assign rst_s_n = sync_q[1];

  arith_drv_timer #(
    .LIMIT (TIMEOUT)
  ) u_tmr (
    .clk   (clk),
    .rst_n (rst_s_n),
    .clr_i (state_d == S_START),
    .inc_i (state_q == S_WAIT),
    .tc_o  (tmo)
  );

  // next state, operand latch, response capture, output decode
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    tag_d   = tag_q;
    out_d   = out_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && out_q.req_ready) begin
          state_d = S_START;
          op_a_d  = bus.req_a;
          op_b_d  = bus.req_b;
          tag_d   = bus.req_tag;
        end
      end
      S_START: begin
        state_d = S_ADD;
        ph_d    = '0;
      end
      S_ADD: begin
        if (ph_q == ADD_LAST) begin
          ph_d    = '0;
          state_d = (MUL_GAP == 0) ? S_MUL : S_GAP;
        end else begin
          ph_d = ph_q + 8'd1;
        end
      end
      S_GAP: begin
        if (ph_q == GAP_LAST) state_d = S_MUL;
        else                  ph_d    = ph_q + 8'd1;
      end
      S_MUL: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.done) begin
          state_d          = S_RESP;
          out_d.rsp_result = bus.result;
          out_d.rsp_fifo   = bus.fifo_out;
          out_d.rsp_tag    = tag_q;
          out_d.rsp_err    = 1'b0;
        end else if (tmo) begin
          state_d          = S_RESP;
          out_d.rsp_result = '0;
          out_d.rsp_fifo   = '0;
          out_d.rsp_tag    = tag_q;
          out_d.rsp_err    = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy            = (state_d != S_IDLE) && (state_d != S_RESP);
    out_d.req_ready = (state_d == S_IDLE);
    out_d.start     = (state_d == S_START);
    out_d.add_en    = (state_d == S_ADD);
    out_d.mul_en    = (state_d == S_MUL);
    out_d.rsp_valid = (state_d == S_RESP);
    out_d.a         = busy ? op_a_d : '0;
    out_d.b         = busy ? op_b_d : '0;
    out_d.fifo_in   = (state_d == S_START) ? tag_d : '0;
  end

  // state, operands and registered outputs
  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      tag_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      tag_q   <= tag_d;
      out_q   <= out_d;
    end
  end

  assign bus.req_ready  = out_q.req_ready;
  assign bus.start      = out_q.start;
  assign bus.add_en     = out_q.add_en;
  assign bus.mul_en     = out_q.mul_en;
  assign bus.a          = out_q.a;
  assign bus.b          = out_q.b;
  assign bus.fifo_in    = out_q.fifo_in;
  assign bus.rsp_valid  = out_q.rsp_valid;
  assign bus.rsp_result = out_q.rsp_result;
  assign bus.rsp_fifo   = out_q.rsp_fifo;
  assign bus.rsp_tag    = out_q.rsp_tag;
  assign bus.rsp_err    = out_q.rsp_err;

endmodule

// File: tb/tb_arith_job_driver.sv
// tb_arith_job_driver: directed jobs against a target model.
// Two instances: defaults, and ADD_CYC=3 MUL_GAP=0 TIMEOUT=4.
module tb_arith_job_driver;

  typedef struct packed {
    logic        req_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] tag;
    logic        rsp_ready;
  } drv_t;

  typedef struct packed {
    logic        req_ready;
    logic        start;
    logic        add_en;
    logic        mul_en;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] fifo_in;
    logic        rsp_valid;
    logic [15:0] rsp_result;
    logic [15:0] rsp_fifo;
    logic [15:0] rsp_tag;
    logic        rsp_err;
  } obs_t;

  typedef struct {
    logic [15:0] tag;
    logic [15:0] res;
    logic [15:0] fifo;
    logic        err;
  } exp_t;

  logic       clk = 1'b0;
  logic [1:0] rst_n;
  drv_t       drv [2];
  logic [7:0] done_lat [2];
  exp_t       exp_q [$];
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int AC = (g == 0) ? 1 : 3;
    localparam int MG = (g == 0) ? 1 : 0;
    localparam int TO = (g == 0) ? 64 : 4;

    arith_job_driver_if ifc ();

    arith_job_driver #(
      .ADD_CYC (AC),
      .MUL_GAP (MG),
      .TIMEOUT (TO)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n[g]),
      .bus   (ifc.master)
    );

    logic [7:0]  wcnt;
    logic [15:0] acc;
    logic [15:0] res;
    logic [15:0] ftag;
    obs_t        o;

    assign ifc.req_valid = drv[g].req_valid;
    assign ifc.req_a     = drv[g].a;
    assign ifc.req_b     = drv[g].b;
    assign ifc.req_tag   = drv[g].tag;
    assign ifc.rsp_ready = drv[g].rsp_ready;
    assign ifc.result    = res;
    assign ifc.fifo_out  = ftag;
    assign ifc.done      = (done_lat[g] != 8'd0) && (wcnt == done_lat[g]);

    assign o = {ifc.req_ready, ifc.start, ifc.add_en, ifc.mul_en,
                ifc.a, ifc.b, ifc.fifo_in, ifc.rsp_valid,
                ifc.rsp_result, ifc.rsp_fifo, ifc.rsp_tag, ifc.rsp_err};

    // target: add, then multiply-accumulate, done N cycles after mul
    always @(posedge clk) begin
      if (!rst_n[g]) begin
        wcnt <= '0;
        acc  <= '0;
        res  <= '0;
        ftag <= '0;
      end else begin
        if (ifc.start) begin
          ftag <= ifc.fifo_in;
          wcnt <= '0;
        end
        if (ifc.add_en) acc <= 16'(ifc.a) + 16'(ifc.b);
        if (ifc.mul_en) begin
          res  <= acc + 16'(ifc.a) * 16'(ifc.b);
          wcnt <= 8'd1;
        end else if (wcnt != 8'd0 && wcnt != 8'hFF) begin
          wcnt <= wcnt + 8'd1;
        end
      end
    end
  end

  function automatic obs_t ob(input int d);
    if (d == 0) return g_dut[0].o;
    return g_dut[1].o;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int d, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] tag, input bit err, input bit push);
    logic [15:0] ea, eb;
    exp_t e;
    ea = 16'(a);
    eb = 16'(b);
    drv[d].req_valid = 1'b1;
    drv[d].a = a;
    drv[d].b = b;
    drv[d].tag = tag;
    e.tag  = tag;
    e.res  = err ? 16'h0 : ea * eb + ea + eb;
    e.fifo = err ? 16'h0 : tag;
    e.err  = err;
    if (push) exp_q.push_back(e);
  endtask

  task automatic run(input int d, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] tag, input int A, input int G,
                     input int N);
    int t = 0;
    int t_st = -1;
    int t_mul = -1;
    int n_add = 0;
    bit ex = 1'b1;
    obs_t o;
    while (!ob(d).req_ready && t < 20) begin
      step();
      t++;
    end
    chk("ready_before_accept", ob(d).req_ready, 1);
    step();
    drv[d].req_valid = 1'b0;
    t = 1;
    o = ob(d);
    chk("a_in_start", o.a, a);
    chk("b_in_start", o.b, b);
    chk("fifo_in_start", o.fifo_in, tag);
    while (!o.rsp_valid && t < 300) begin
      if ($countones({o.start, o.add_en, o.mul_en}) > 1) ex = 1'b0;
      if (o.start && t_st < 0) t_st = t;
      if (o.add_en) n_add++;
      if (o.mul_en) t_mul = t;
      step();
      t++;
      o = ob(d);
    end
    chk("start_cycle", t_st, 1);
    chk("add_cycles", n_add, A);
    chk("mul_cycle", t_mul, 2 + A + G);
    chk("rsp_cycle", t, 3 + A + G + N);
    chk("strobe_excl", ex, 1);
    chk("ab_zero_in_resp", {o.a, o.b}, 0);
  endtask

  task automatic rsp_take(input int d, input int hold);
    obs_t s;
    exp_t e;
    bit st = 1'b1;
    s = ob(d);
    chk("rsp_valid", s.rsp_valid, 1);
    if (exp_q.size() == 0) begin
      chk("sb_nonempty", exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    drv[d].rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (ob(d) !== s) st = 1'b0;
    end
    if (hold > 0) begin
      chk("bp_stable", st, 1);
      chk("bp_req_ready", s.req_ready, 0);
    end
    chk("rsp_tag", s.rsp_tag, e.tag);
    chk("rsp_result", s.rsp_result, e.res);
    chk("rsp_fifo", s.rsp_fifo, e.fifo);
    chk("rsp_err", s.rsp_err, e.err);
    drv[d].rsp_ready = 1'b1;
    step();
    drv[d].rsp_ready = 1'b0;
    s = ob(d);
    chk("rsp_dropped", s.rsp_valid, 0);
    chk("no_same_cycle_accept", s.start, 0);
    chk("idle_ready", s.req_ready, 1);
  endtask

  initial begin
    int t;
    bit seen;
    obs_t o;
    rst_n = 2'b00;
    drv[0] = '0;
    drv[1] = '0;
    done_lat[0] = 8'd0;
    done_lat[1] = 8'd0;
    repeat (3) step();
    chk("reset_outs0", ob(0), 0);
    chk("reset_outs1", ob(1), 0);
    rst_n = 2'b11;
    t = 0;
    while (!ob(0).req_ready && t < 10) begin
      step();
      t++;
    end
    chk("ready_after_release", ob(0).req_ready, 1);
    chk("release_latency", t, 3);
    chk("ready_after_release1", ob(1).req_ready, 1);

    done_lat[0] = 8'd3;
    req(0, 8'd3, 8'd5, 16'h00A5, 1'b0, 1'b1);
    run(0, 8'd3, 8'd5, 16'h00A5, 1, 1, 3);
    rsp_take(0, 0);

    req(0, 8'd7, 8'd9, 16'h1234, 1'b0, 1'b1);
    run(0, 8'd7, 8'd9, 16'h1234, 1, 1, 3);
    req(0, 8'd2, 8'd2, 16'h0055, 1'b0, 1'b1);
    rsp_take(0, 5);
    run(0, 8'd2, 8'd2, 16'h0055, 1, 1, 3);
    rsp_take(0, 0);

    req(0, 8'd1, 8'd2, 16'h0001, 1'b0, 1'b1);
    run(0, 8'd1, 8'd2, 16'h0001, 1, 1, 3);
    req(0, 8'd200, 8'd250, 16'h0002, 1'b0, 1'b1);
    rsp_take(0, 0);
    run(0, 8'd200, 8'd250, 16'h0002, 1, 1, 3);
    rsp_take(0, 0);

    req(0, 8'd6, 8'd7, 16'h0BEE, 1'b0, 1'b0);
    t = 0;
    while (!ob(0).req_ready && t < 10) begin
      step();
      t++;
    end
    step();
    drv[0].req_valid = 1'b0;
    t = 0;
    while (!ob(0).add_en && t < 10) begin
      step();
      t++;
    end
    step();
    o = ob(0);
    chk("in_gap_strobes", {o.start, o.add_en, o.mul_en}, 0);
    chk("in_gap_a", o.a, 6);
    rst_n[0] = 1'b0;
    #1;
    o = ob(0);
    chk("rst_strobes",
        {o.start, o.add_en, o.mul_en, o.rsp_valid, o.rsp_err}, 0);
    chk("rst_data",
        {o.a, o.b, o.fifo_in, o.rsp_result, o.rsp_fifo, o.rsp_tag}, 0);
    chk("rst_ready", o.req_ready, 0);
    step();
    step();
    rst_n[0] = 1'b1;
    t = 0;
    seen = 1'b0;
    while (!ob(0).req_ready && t < 10) begin
      step();
      t++;
      if (ob(0).rsp_valid) seen = 1'b1;
    end
    chk("ready_after_mid_rst", ob(0).req_ready, 1);
    repeat (6) begin
      step();
      if (ob(0).rsp_valid || ob(0).start) seen = 1'b1;
    end
    chk("no_rsp_after_abandon", seen, 0);

    done_lat[1] = 8'd0;
    req(1, 8'd9, 8'd9, 16'h0BAD, 1'b1, 1'b1);
    run(1, 8'd9, 8'd9, 16'h0BAD, 3, 0, 4);
    rsp_take(1, 0);

    done_lat[1] = 8'd4;
    req(1, 8'd10, 8'd20, 16'h0C0C, 1'b0, 1'b1);
    run(1, 8'd10, 8'd20, 16'h0C0C, 3, 0, 4);
    rsp_take(1, 0);

    chk("sb_drained", exp_q.size(), 0);
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
